// File: rtl/controller_pkg.sv
// Shared encodings for the two-bit up/down/clear state controller.
package controller_pkg;

  // State encoding is also the externally visible {F1,F0} value.
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  // Command is the concatenation {X,Y}.
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    UP    = 2'b01,
    DOWN  = 2'b10,
    CLEAR = 2'b11
  } cmd_t;

endpackage

// File: rtl/controller_next_state.sv
// Combinational next-state decode: applies the {X,Y} command to the current state.
module controller_next_state
  import controller_pkg::*;
(
  input  state_t state,
  input  logic   X,
  input  logic   Y,
  output state_t next_state
);

  state_t state_up;
  state_t state_dn;
  cmd_t   cmd;

  assign cmd = cmd_t'({X, Y});

  // Neighbour states for the count directions, wrapping modulo four.
  always_comb begin
    state_up = S0;
    state_dn = S0;
    case (state)
      S0:      begin state_up = S1; state_dn = S3; end
      S1:      begin state_up = S2; state_dn = S0; end
      S2:      begin state_up = S3; state_dn = S1; end
      S3:      begin state_up = S0; state_dn = S2; end
      default: begin state_up = S0; state_dn = S0; end
    endcase
  end

  // Command select; an unknown command falls to the default branch and holds.
  always_comb begin
    next_state = state;
    case (cmd)
      UP:      next_state = state_up;
      DOWN:    next_state = state_dn;
      CLEAR:   next_state = S0;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Two-bit Moore controller: state register plus direct state-bit outputs.
//
//   state | meaning
//   ------+---------------------------------------------
//   S0    | count 0, reset / clear target ({F1,F0}=00)
//   S1    | count 1 ({F1,F0}=01)
//   S2    | count 2 ({F1,F0}=10)
//   S3    | count 3 ({F1,F0}=11)
module controller
  import controller_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic X,
  input  logic Y,
  output logic F1,
  output logic F0
);

  state_t state_q;
  state_t state_d;

  controller_next_state u_next_state (
    .state      (state_q),
    .X          (X),
    .Y          (Y),
    .next_state (state_d)
  );

  // State register; synchronous reset overrides any command.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  assign F1 = state_q[1];
  assign F0 = state_q[0];

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: driver pushes expected state, monitor checks after each edge.
module tb_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic X     = 1'b0;
  logic Y     = 1'b0;
  logic F1;
  logic F0;

  controller dut (
    .clock (clock),
    .reset (reset),
    .X     (X),
    .Y     (Y),
    .F1    (F1),
    .F0    (F0)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_err = 0;
  int         model = 0;
  logic [1:0] exp_q[$];
  string      tag_q[$];

  // Reference model: the state is just a count modulo four.
  task automatic step(input logic r, input logic x, input logic y,
                      input bit glitch, input string tag);
    @(negedge clock);
    reset = r;
    X     = x;
    Y     = y;
    if (r === 1'b1)                       model = 0;
    else if ($isunknown({x, y}))          model = model;
    else if (x && y)                      model = 0;
    else if (!x && y)                     model = (model + 1) % 4;
    else if (x && !y)                     model = (model + 3) % 4;
    exp_q.push_back(2'(model));
    tag_q.push_back(tag);
    if (glitch) begin
      #1 X = ~x;
      #2 X = x;
    end
  endtask

  // Monitor: one expected value is consumed per rising edge.
  initial begin
    logic [1:0] e;
    string      t;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if ({F1, F0} !== e) begin
          n_err++;
          $display("FAIL %s: got %b expected %b at %0t", t, {F1, F0}, e, $time);
        end
      end
    end
  end

  initial begin
    logic [1:0] prev;
    logic       rx, ry, rr;

    for (int i = 0; i < 5; i++) step(1'b1, 1'bx, 1'bx, 1'b0, "reset_hold");
    step(1'b0, 1'b0, 1'b0, 1'b0, "reset_release");

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "up_wrap");

    step(1'b0, 1'b1, 1'b1, 1'b0, "clear_pre_down");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "down_wrap");

    step(1'b0, 1'b1, 1'b0, 1'b0, "to_s2");
    step(1'b0, 1'b1, 1'b1, 1'b0, "clear_from_s2");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "hold_after_clear");

    step(1'b0, 1'b0, 1'b1, 1'b0, "to_s1");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "glitch_hold");

    step(1'b0, 1'b1, 1'b0, 1'b0, "to_s0");
    step(1'b0, 1'b1, 1'b0, 1'b0, "to_s3");
    prev = 2'(model);
    step(1'b1, 1'b0, 1'b1, 1'b0, "reset_priority");
    #2;
    n_cmp++;
    if ({F1, F0} !== prev) begin
      n_err++;
      $display("FAIL reset_not_async: got %b expected %b at %0t", {F1, F0}, prev, $time);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_reset_hold");

    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 19) == 0);
      rx = 1'($urandom_range(0, 1));
      ry = 1'($urandom_range(0, 1));
      step(rr, rx, ry, 1'($urandom_range(0, 1)), "random");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
